// File: rtl/eth_sw_nxn.sv
// eth_sw_nxn: N-port packet switch, per-output RR arbiter with packet lock,
// one egress FIFO per output. ETH_SW_PKT_STATS_EN adds pkt_cnt/drop_cnt.
module eth_sw_nxn #(
  parameter int PORT_COUNT = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int DEST_LSB   = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PORT_COUNT*DATA_WIDTH-1:0] in_data,
  input  logic [PORT_COUNT-1:0]            in_valid,
  input  logic [PORT_COUNT-1:0]            in_sop,
  input  logic [PORT_COUNT-1:0]            in_eop,
  output logic [PORT_COUNT-1:0]            in_ready,
  input  logic [PORT_COUNT-1:0]            rd_en,
  output logic [PORT_COUNT*DATA_WIDTH-1:0] out_data,
  output logic [PORT_COUNT-1:0]            out_valid,
  output logic [PORT_COUNT-1:0]            out_sop,
  output logic [PORT_COUNT-1:0]            out_eop,
  output logic [PORT_COUNT-1:0]            stall_full,
  output logic [PORT_COUNT-1:0]            stall_empty
`ifdef ETH_SW_PKT_STATS_EN
  ,
  output logic [PORT_COUNT*16-1:0]         pkt_cnt,
  output logic [PORT_COUNT*16-1:0]         drop_cnt
`endif
);
  localparam int P  = PORT_COUNT;
  localparam int DW = DATA_WIDTH;
  localparam int PB = $clog2(PORT_COUNT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DW + 2;

  typedef enum logic [1:0] {IDLE, OPEN, DROP} in_st_e;

  in_st_e        st_q    [P];
  in_st_e        st_d    [P];
  logic [PB-1:0] dest_q  [P];
  logic [PB-1:0] dest_d  [P];
  logic [PB-1:0] owner_q [P];
  logic [PB-1:0] owner_d [P];
  logic [PB-1:0] rr_q    [P];
  logic [PB-1:0] rr_d    [P];
  logic [AW-1:0] wp_q    [P];
  logic [AW-1:0] wp_d    [P];
  logic [AW-1:0] rp_q    [P];
  logic [AW-1:0] rp_d    [P];
  logic [CW-1:0] cnt_q   [P];
  logic [CW-1:0] cnt_d   [P];
  logic [P-1:0]  lock_q, lock_d;
  logic [EW-1:0] fifo_mem [P][FIFO_DEPTH];

  logic [P*DW-1:0] out_data_q, out_data_d;
  logic [P-1:0]    out_valid_q, out_valid_d;
  logic [P-1:0]    out_sop_q, out_sop_d;
  logic [P-1:0]    out_eop_q, out_eop_d;

  logic [P-1:0]  full, empty, dest_ok;
  logic [PB-1:0] sop_dest [P];
  logic [P-1:0]  gnt_vld;
  logic [PB-1:0] gnt_idx [P];
  logic [PB-1:0] cand;
  logic          req;
  logic [P-1:0]  rdy, wr_en;
  logic [PB-1:0] wr_dst [P];
  logic [P-1:0]  push, pop, wsop, weop;
  logic [PB-1:0] wsrc [P];
  logic [DW-1:0] wdata [P];

  // FIFO flags and sop destination decode
  always_comb begin
    for (int i = 0; i < P; i++) begin
      full[i]     = (cnt_q[i] == CW'(FIFO_DEPTH));
      empty[i]    = (cnt_q[i] == '0);
      sop_dest[i] = in_data[i*DW+DEST_LSB +: PB];
      dest_ok[i]  = (int'(sop_dest[i]) < P);
    end
  end

  // Per-output grant: lock owner, else first requester after rr pointer
  always_comb begin
    cand = '0;
    req  = 1'b0;
    for (int o = 0; o < P; o++) begin
      gnt_vld[o] = lock_q[o];
      gnt_idx[o] = owner_q[o];
      if (!lock_q[o]) begin
        for (int k = 1; k <= P; k++) begin
          cand = PB'((int'(rr_q[o]) + k) % P);
          req  = in_valid[cand] && in_sop[cand]
              && (st_q[cand] == IDLE) && dest_ok[cand]
              && (sop_dest[cand] == PB'(o));
          if (!gnt_vld[o] && req) begin
            gnt_vld[o] = 1'b1;
            gnt_idx[o] = cand;
          end
        end
      end
    end
  end

  // Ingress state machines, ready and write requests
  always_comb begin
    for (int i = 0; i < P; i++) begin
      st_d[i]   = st_q[i];
      dest_d[i] = dest_q[i];
      rdy[i]    = 1'b0;
      wr_en[i]  = 1'b0;
      wr_dst[i] = dest_q[i];
      case (st_q[i])
        IDLE: begin
          if (!in_sop[i] || !dest_ok[i]) begin
            rdy[i] = 1'b1;
          end else begin
            wr_dst[i] = sop_dest[i];
            wr_en[i]  = 1'b1;
            rdy[i]    = gnt_vld[sop_dest[i]]
                     && (gnt_idx[sop_dest[i]] == PB'(i))
                     && !full[sop_dest[i]];
          end
          if (in_valid[i] && rdy[i] && in_sop[i] && !in_eop[i]) begin
            st_d[i]   = dest_ok[i] ? OPEN : DROP;
            dest_d[i] = sop_dest[i];
          end
        end
        OPEN: begin
          rdy[i]   = !full[dest_q[i]];
          wr_en[i] = 1'b1;
          if (in_valid[i] && rdy[i] && in_eop[i]) st_d[i] = IDLE;
        end
        DROP: begin
          rdy[i] = 1'b1;
          if (in_valid[i] && in_eop[i]) st_d[i] = IDLE;
        end
        default: st_d[i] = IDLE;
      endcase
      wr_en[i] = wr_en[i] && in_valid[i] && rdy[i];
    end
  end

  // Egress write mux, lock/rr update, FIFO pointers and output regs
  always_comb begin
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_valid_d = '0;
    lock_d      = lock_q;
    for (int o = 0; o < P; o++) begin
      push[o]    = 1'b0;
      wsop[o]    = 1'b0;
      weop[o]    = 1'b0;
      wdata[o]   = '0;
      wsrc[o]    = '0;
      owner_d[o] = owner_q[o];
      rr_d[o]    = rr_q[o];
      for (int i = 0; i < P; i++) begin
        if (wr_en[i] && (wr_dst[i] == PB'(o))) begin
          push[o]  = 1'b1;
          wsrc[o]  = PB'(i);
          wsop[o]  = (st_q[i] == IDLE);
          weop[o]  = in_eop[i];
          wdata[o] = in_data[i*DW +: DW];
        end
      end
      if (push[o]) begin
        lock_d[o] = !weop[o];
        if (wsop[o]) begin
          owner_d[o] = wsrc[o];
          rr_d[o]    = wsrc[o];
        end
      end
      pop[o]  = rd_en[o] && !empty[o];
      wp_d[o] = push[o] ? wp_q[o] + AW'(1) : wp_q[o];
      rp_d[o] = pop[o] ? rp_q[o] + AW'(1) : rp_q[o];
      cnt_d[o] = cnt_q[o] + CW'(push[o]) - CW'(pop[o]);
      if (pop[o]) begin
        out_valid_d[o]          = 1'b1;
        out_sop_d[o]            = fifo_mem[o][rp_q[o]][EW-1];
        out_eop_d[o]            = fifo_mem[o][rp_q[o]][DW];
        out_data_d[o*DW +: DW]  = fifo_mem[o][rp_q[o]][DW-1:0];
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < P; i++) begin
        st_q[i]    <= IDLE;
        dest_q[i]  <= '0;
        owner_q[i] <= '0;
        rr_q[i]    <= PB'(P - 1);
        wp_q[i]    <= '0;
        rp_q[i]    <= '0;
        cnt_q[i]   <= '0;
      end
      lock_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= '0;
      out_sop_q   <= '0;
      out_eop_q   <= '0;
    end else begin
      st_q        <= st_d;
      dest_q      <= dest_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      cnt_q       <= cnt_d;
      lock_q      <= lock_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
    end
  end

  // FIFO storage; contents are don't-care while count is zero
  always_ff @(posedge clk) begin
    for (int o = 0; o < P; o++)
      if (push[o])
        fifo_mem[o][wp_q[o]] <= {wsop[o], weop[o], wdata[o]};
  end

  assign in_ready    = rdy & ~{P{rst}};
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_sop     = out_sop_q;
  assign out_eop     = out_eop_q;
  assign stall_full  = full;
  assign stall_empty = empty;

`ifdef ETH_SW_PKT_STATS_EN
  logic [P*16-1:0] pkt_q, pkt_d, drp_q, drp_d;

  // Packet and drop counters; accepted words not written are drops
  always_comb begin
    pkt_d = pkt_q;
    drp_d = drp_q;
    for (int i = 0; i < P; i++) begin
      pkt_d[i*16 +: 16] = pkt_q[i*16 +: 16]
                        + 16'(push[i] & weop[i]);
      drp_d[i*16 +: 16] = drp_q[i*16 +: 16]
                        + 16'(in_valid[i] & rdy[i] & ~wr_en[i]);
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_q <= '0;
      drp_q <= '0;
    end else begin
      pkt_q <= pkt_d;
      drp_q <= drp_d;
    end
  end

  assign pkt_cnt  = pkt_q;
  assign drop_cnt = drp_q;
`endif
endmodule
